// File: rtl/dma_r_burst_ctrl.sv
// Read-DMA burst sequencer: splits a transfer into INCR bursts that respect
// MAX_BURST and 4 KB page boundaries, issues them to the read engine and
// forwards returned beats to a valid/ready consumer.
module dma_r_burst_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DMA_DATA_W = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_W-1:0]      eng_dma_len,
  input  logic                  eng_dma_ready,
  input  logic                  eng_error,
  output logic                  eng_valid,
  output logic [ADDR_W-1:0]     eng_addr,
  input  logic                  eng_ready,
  input  logic [DMA_DATA_W-1:0] eng_rdata,
  output logic                  out_valid,
  output logic [DMA_DATA_W-1:0] out_data,
  input  logic                  out_ready
);

  localparam int unsigned B       = DMA_DATA_W / 8;
  localparam int unsigned BURST_W = LEN_W + 1;
  localparam int unsigned MAX_A   = (CNT_W > 13) ? CNT_W : 13;
  localparam int unsigned CALC_W  = (MAX_A > BURST_W) ? MAX_A : BURST_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ENG, S_ISSUE, S_DATA, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [BURST_W-1:0]  burst_q;
  logic [BURST_W-1:0]  beat_cnt_q;
  logic [LEN_W-1:0]    dma_len_q;
  logic                error_q;
  logic                burst_seen_q;

  logic                misaligned_c;
  logic                beat_xfer_c;
  logic                last_beat_c;
  logic                abort_c;
  logic [CNT_W-1:0]    rem_after_c;
  logic [12:0]         room_bytes_c;
  logic [CALC_W-1:0]   room_c;
  logic [CALC_W-1:0]   burst_c;

  assign misaligned_c = (base_addr & ADDR_W'(B - 1)) != '0;
  assign beat_xfer_c  = eng_ready & out_ready;
  assign last_beat_c  = (beat_cnt_q == (burst_q - BURST_W'(1)));
  assign abort_c      = burst_seen_q & eng_error;
  assign rem_after_c  = remaining_q - CNT_W'(burst_q);
  assign room_bytes_c = 13'd4096 - {1'b0, addr_q[11:0]};
  assign room_c       = CALC_W'(room_bytes_c / 13'(B));

  // Next burst size: min(remaining, MAX_BURST, beats left in the 4 KB page)
  always_comb begin
    burst_c = CALC_W'(remaining_q);
    if (CALC_W'(MAX_BURST) < burst_c) burst_c = CALC_W'(MAX_BURST);
    if (room_c < burst_c)             burst_c = room_c;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misaligned_c || (xfer_len == '0)) state_d = S_DONE;
          else                                  state_d = S_WAIT_ENG;
        end
      end
      S_WAIT_ENG: begin
        if (abort_c)            state_d = S_DONE;
        else if (eng_dma_ready) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_DATA;
      S_DATA: begin
        if (beat_xfer_c && last_beat_c)
          state_d = (rem_after_c == '0) ? S_DONE : S_WAIT_ENG;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; engine valid and consumer valid pass straight through in DATA
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    error       = error_q;
    eng_addr    = addr_q;
    eng_dma_len = dma_len_q;
    eng_valid   = 1'b0;
    out_valid   = 1'b0;
    out_data    = eng_rdata;
    if (state_q == S_ISSUE) eng_valid = 1'b1;
    if (state_q == S_DATA) begin
      eng_valid = out_ready;
      out_valid = eng_ready;
    end
  end

  // Transfer bookkeeping: address, remaining beats, burst size, beat count, error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      dma_len_q    <= '0;
      error_q      <= 1'b0;
      burst_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            remaining_q  <= xfer_len;
            beat_cnt_q   <= '0;
            error_q      <= misaligned_c;
            burst_seen_q <= 1'b0;
          end
        end
        S_WAIT_ENG: begin
          if (abort_c) begin
            error_q <= 1'b1;
          end else if (eng_dma_ready) begin
            burst_q   <= BURST_W'(burst_c);
            dma_len_q <= LEN_W'(burst_c - CALC_W'(1));
          end
        end
        S_DATA: begin
          if (beat_xfer_c) begin
            if (last_beat_c) begin
              remaining_q  <= rem_after_c;
              addr_q       <= addr_q + ADDR_W'(burst_q) * ADDR_W'(B);
              beat_cnt_q   <= '0;
              burst_seen_q <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + BURST_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_r_burst_ctrl.sv
// Directed bench for dma_r_burst_ctrl with a behavioural read-engine model.
module tb_dma_r_burst_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  xfer_len;
  logic              busy, done, error;
  logic [LEN_W-1:0]  eng_dma_len;
  logic              eng_dma_ready;
  logic              eng_error;
  logic              eng_valid;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_ready;
  logic [DW-1:0]     eng_rdata;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;

  int tests  = 0;
  int failed = 0;

  dma_r_burst_ctrl #(
    .ADDR_W(ADDR_W), .DMA_DATA_W(DW), .LEN_W(LEN_W), .CNT_W(CNT_W), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .error(error), .eng_dma_len(eng_dma_len),
    .eng_dma_ready(eng_dma_ready), .eng_error(eng_error), .eng_valid(eng_valid),
    .eng_addr(eng_addr), .eng_ready(eng_ready), .eng_rdata(eng_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [ADDR_W-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Engine model: accepts a burst on eng_valid while idle, then streams beats
  logic [ADDR_W-1:0] e_addr;
  int                e_left;
  logic              e_busy;
  logic [ADDR_W-1:0] burst_addr_q[$];
  int                burst_len_q[$];
  logic [DW-1:0]     beats_q[$];
  int                done_hi = 0;
  int                ev_cnt  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_busy        <= 1'b0;
      eng_dma_ready <= 1'b1;
      eng_ready     <= 1'b0;
      eng_rdata     <= '0;
      e_left        <= 0;
      e_addr        <= '0;
    end else if (!e_busy) begin
      if (eng_valid) begin
        burst_addr_q.push_back(eng_addr);
        burst_len_q.push_back(int'(eng_dma_len));
        e_busy        <= 1'b1;
        eng_dma_ready <= 1'b0;
        e_addr        <= eng_addr;
        e_left        <= int'(eng_dma_len) + 1;
        eng_ready     <= 1'b1;
        eng_rdata     <= mem(eng_addr);
      end
    end else if (eng_ready && eng_valid) begin
      if (e_left == 1) begin
        e_busy        <= 1'b0;
        eng_ready     <= 1'b0;
        eng_dma_ready <= 1'b1;
      end else begin
        e_left    <= e_left - 1;
        e_addr    <= e_addr + 32'd4;
        eng_rdata <= mem(e_addr + 32'd4);
      end
    end
  end

  // Consumer / status monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) beats_q.push_back(out_data);
      if (done) done_hi <= done_hi + 1;
      if (eng_valid) ev_cnt <= ev_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    burst_addr_q.delete();
    burst_len_q.delete();
    beats_q.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    @(negedge clk);
    base_addr = a;
    xfer_len  = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse; a timeout is reported as a failed check
  task automatic wait_done(input string tag, input int d0);
    int k;
    k = 0;
    while (done_hi == d0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_hi != d0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_width"}, 64'(done_hi - d0), 64'd1);
  endtask

  task automatic check_beats(input string tag, input logic [ADDR_W-1:0] a, input int n);
    int bad;
    bad = 0;
    check({tag, "_beat_count"}, 64'(beats_q.size()), 64'(n));
    for (int i = 0; i < beats_q.size() && i < n; i++)
      if (beats_q[i] !== mem(a + ADDR_W'(4 * i))) bad++;
    check({tag, "_beat_data_errs"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int d0, ev0, bad, k;
    rst = 1'b1; start = 1'b0; base_addr = '0; xfer_len = '0;
    eng_error = 1'b0; out_ready = 1'b1;
    #12;
    // Reset values
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_eng_valid", 64'(eng_valid), 64'd0);
    check("rst_eng_addr", 64'(eng_addr), 64'd0);
    check("rst_eng_dma_len", 64'(eng_dma_len), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single short burst, plus first-burst latency
    clear_logs(); d0 = done_hi;
    pulse_start(32'h0, 16'd5);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    check("t1_valid_wait", 64'(eng_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_valid_issue", 64'(eng_valid), 64'd1);
    check("t1_issue_len", 64'(eng_dma_len), 64'd4);
    check("t1_issue_addr", 64'(eng_addr), 64'h0);
    wait_done("t1", d0);
    check("t1_bursts", 64'(burst_len_q.size()), 64'd1);
    check_beats("t1", 32'h0, 5);
    check("t1_error", 64'(error), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: 40 beats -> 16/16/8
    clear_logs(); d0 = done_hi;
    pulse_start(32'h0, 16'd40);
    wait_done("t2", d0);
    check("t2_bursts", 64'(burst_len_q.size()), 64'd3);
    if (burst_len_q.size() == 3) begin
      check("t2_a0", 64'(burst_addr_q[0]), 64'h0);
      check("t2_l0", 64'(burst_len_q[0]), 64'd15);
      check("t2_a1", 64'(burst_addr_q[1]), 64'h40);
      check("t2_l1", 64'(burst_len_q[1]), 64'd15);
      check("t2_a2", 64'(burst_addr_q[2]), 64'h80);
      check("t2_l2", 64'(burst_len_q[2]), 64'd7);
    end
    check_beats("t2", 32'h0, 40);

    // 3: 4 KB boundary split
    clear_logs(); d0 = done_hi;
    pulse_start(32'hFF8, 16'd6);
    wait_done("t3", d0);
    check("t3_bursts", 64'(burst_len_q.size()), 64'd2);
    if (burst_len_q.size() == 2) begin
      check("t3_a0", 64'(burst_addr_q[0]), 64'hFF8);
      check("t3_l0", 64'(burst_len_q[0]), 64'd1);
      check("t3_a1", 64'(burst_addr_q[1]), 64'h1000);
      check("t3_l1", 64'(burst_len_q[1]), 64'd3);
    end
    check_beats("t3", 32'hFF8, 6);

    // 4: consumer backpressure toggling every cycle
    clear_logs(); d0 = done_hi; bad = 0; k = 0;
    pulse_start(32'h100, 16'd20);
    while (done_hi == d0 && k < 3000) begin
      @(negedge clk);
      out_ready = ~out_ready;
      #1;
      if (eng_ready && (eng_valid !== out_ready)) bad++;
      k++;
    end
    out_ready = 1'b1;
    check("t4_valid_tracks_ready_errs", 64'(bad), 64'd0);
    check("t4_done_seen", 64'(done_hi != d0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_bursts", 64'(burst_len_q.size()), 64'd2);
    check_beats("t4", 32'h100, 20);

    // 6a: engine error after first burst aborts the rest
    clear_logs(); d0 = done_hi; k = 0;
    pulse_start(32'h0, 16'd40);
    while (burst_len_q.size() == 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    eng_error = 1'b1;
    wait_done("t6err", d0);
    check("t6err_bursts", 64'(burst_len_q.size()), 64'd1);
    check("t6err_error", 64'(error), 64'd1);
    eng_error = 1'b0;

    // 5a: misaligned base (also clears the previous sticky error on start)
    clear_logs(); d0 = done_hi; ev0 = ev_cnt;
    pulse_start(32'h2, 16'd4);
    check("t5_mis_done", 64'(done), 64'd1);
    check("t5_mis_error", 64'(error), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_mis_no_valid", 64'(ev_cnt - ev0), 64'd0);
    check("t5_mis_done_width", 64'(done_hi - d0), 64'd1);

    // 5b: zero length completes cleanly and clears error
    d0 = done_hi; ev0 = ev_cnt;
    pulse_start(32'h40, 16'd0);
    check("t5_zero_done", 64'(done), 64'd1);
    check("t5_zero_error", 64'(error), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_zero_no_valid", 64'(ev_cnt - ev0), 64'd0);

    // 6b: reset in the middle of a data phase
    clear_logs(); k = 0;
    pulse_start(32'h0, 16'd40);
    while (beats_q.size() < 20 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("t6rst_in_data", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6rst_eng_valid", 64'(eng_valid), 64'd0);
    check("t6rst_busy", 64'(busy), 64'd0);
    check("t6rst_done", 64'(done), 64'd0);
    check("t6rst_error", 64'(error), 64'd0);
    check("t6rst_eng_addr", 64'(eng_addr), 64'h0);
    check("t6rst_eng_dma_len", 64'(eng_dma_len), 64'd0);
    check("t6rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
